// File: rtl/sdram_init_refresh_seq.sv
// sdram_init_refresh_seq: SDRAM power-up init and periodic refresh sequencer (SDRAM_AUTO_REFRESH_EN enables refresh)
module sdram_init_refresh_seq #(
  parameter int ADDR_W = 11,
  parameter int BA_W = 2,
  parameter int T_POWERUP = 20000,
  parameter int T_RP = 2,
  parameter int T_RFC = 7,
  parameter int T_MRD = 2,
  parameter int INIT_REFRESHES = 8,
  parameter int T_REFI = 1560,
  parameter int MODE_REG = 'h020
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              cke,
  output logic              cs_n,
  output logic              ras_n,
  output logic              cas_n,
  output logic              we_n,
  output logic [BA_W-1:0]   ba,
  output logic [ADDR_W-1:0] addr,
  output logic              dqmh,
  output logic              dqml,
  output logic              init_done,
  output logic              ref_req,
  input  logic              ref_gnt,
  output logic              ref_busy,
  output logic              ref_overrun
);
  localparam int MAX_A = T_POWERUP > T_RP ? T_POWERUP : T_RP;
  localparam int MAX_B = T_RFC > T_MRD ? T_RFC : T_MRD;
  localparam int MAXT = MAX_A > MAX_B ? MAX_A : MAX_B;
  localparam int CW = $clog2(MAXT) + 1;
  localparam int RW = $clog2(INIT_REFRESHES) + 1;
  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;
  typedef enum logic [2:0] {S_RESET, S_WAIT, S_PRE, S_REF, S_MRS, S_IDLE, S_GNT, S_BUSY} state_t;
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] rc, rc_n;
  logic [3:0] cmd_n;
  logic [ADDR_W-1:0] addr_n;
  logic done_n, req_n, busy_n, ovr_n, expire;
`ifdef SDRAM_AUTO_REFRESH_EN
  localparam int IW = $clog2(T_REFI) + 1;
  logic [IW-1:0] ri;
  assign expire = init_done && ri == '0;
  // refresh interval timer: held loaded until init completes, then free-runs and reloads on expiry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ri <= '0;
    else ri <= (!init_done || ri == '0) ? IW'(T_REFI - 1) : ri - 1'b1;
`else
  assign expire = 1'b0;
`endif
  // next-state and next-output decode; every command is emitted for exactly one cycle
  always_comb begin
    st_n = st;
    cnt_n = (cnt == '0) ? '0 : cnt - 1'b1;
    rc_n = rc;
    cmd_n = NOP;
    addr_n = '0;
    done_n = init_done;
    busy_n = ref_busy;
    case (st)
      S_RESET: begin
        st_n = S_WAIT;
        cnt_n = CW'(T_POWERUP - 1);
      end
      S_WAIT: if (cnt == '0) begin
        st_n = S_PRE;
        cmd_n = PRE;
        addr_n[10] = 1'b1;
        cnt_n = CW'(T_RP - 1);
      end
      S_PRE: if (cnt == '0) begin
        st_n = S_REF;
        cmd_n = REF;
        cnt_n = CW'(T_RFC - 1);
        rc_n = rc + 1'b1;
      end
      S_REF: if (cnt == '0) begin
        if (rc == RW'(INIT_REFRESHES)) begin
          st_n = S_MRS;
          cmd_n = MRS;
          addr_n = ADDR_W'(MODE_REG);
          cnt_n = CW'(T_MRD - 1);
        end else begin
          cmd_n = REF;
          cnt_n = CW'(T_RFC - 1);
          rc_n = rc + 1'b1;
        end
      end
      S_MRS: if (cnt == '0) begin
        st_n = S_IDLE;
        done_n = 1'b1;
      end
      S_IDLE: st_n = (ref_req && ref_gnt) ? S_GNT : S_IDLE;
      S_GNT: begin
        st_n = S_BUSY;
        cmd_n = REF;
        busy_n = 1'b1;
        cnt_n = CW'(T_RFC - 1);
      end
      S_BUSY: if (cnt == '0) begin
        st_n = S_IDLE;
        busy_n = 1'b0;
      end
      default: st_n = S_RESET;
    endcase
    req_n = (st == S_GNT) ? 1'b0 : (expire ? 1'b1 : ref_req);
    ovr_n = ref_overrun | (expire & ref_req);
  end
  // registered state, counters and all pin outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= S_RESET;
      cnt <= '0;
      rc <= '0;
      cke <= 1'b0;
      {cs_n, ras_n, cas_n, we_n} <= 4'b1111;
      addr <= '0;
      ba <= '0;
      {dqmh, dqml} <= 2'b11;
      init_done <= 1'b0;
      ref_req <= 1'b0;
      ref_busy <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      rc <= rc_n;
      cke <= 1'b1;
      {cs_n, ras_n, cas_n, we_n} <= cmd_n;
      addr <= addr_n;
      ba <= '0;
      {dqmh, dqml} <= {2{~done_n}};
      init_done <= done_n;
      ref_req <= req_n;
      ref_busy <= busy_n;
      ref_overrun <= ovr_n;
    end
endmodule

// File: tb/tb_sdram_init_refresh_seq.sv
// tb_sdram_init_refresh_seq: directed self-checking bench for the SDRAM init/refresh sequencer
module tb_sdram_init_refresh_seq;
  logic clk = 1'b0, rst_n = 1'b0, ref_gnt = 1'b0;
  logic cke, cs_n, ras_n, cas_n, we_n, dqmh, dqml, init_done, ref_req, ref_busy, ref_overrun;
  logic [1:0] ba;
  logic [10:0] addr;
  int pass_cnt = 0, total = 0;
  always #5 clk = ~clk;
  sdram_init_refresh_seq #(.ADDR_W(11), .BA_W(2), .T_POWERUP(10), .T_RP(2), .T_RFC(4), .T_MRD(2),
    .INIT_REFRESHES(2), .T_REFI(20), .MODE_REG('h020)) dut (
    .clk(clk), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .dqmh(dqmh), .dqml(dqml), .init_done(init_done), .ref_req(ref_req),
    .ref_gnt(ref_gnt), .ref_busy(ref_busy), .ref_overrun(ref_overrun));
  wire [3:0] cmd = {cs_n, ras_n, cas_n, we_n};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] init_cmd(int e);
    return e == 10 ? 4'b0010 : (e == 12 || e == 16) ? 4'b0001 : e == 20 ? 4'b0000 : 4'b0111;
  endfunction
  task automatic release_reset();
    rst_n = 1'b0;
    ref_gnt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) tick();
    total++;
    if ({cke, cmd} !== 5'b01111) $display("FAIL reset_pins: got %b want 01111", {cke, cmd});
    else pass_cnt++;
    total++;
    if ({addr, ba} !== 13'd0) $display("FAIL reset_addr: got %h want 0", {addr, ba});
    else pass_cnt++;
    total++;
    if ({dqmh, dqml} !== 2'b11) $display("FAIL reset_dqm: got %b want 11", {dqmh, dqml});
    else pass_cnt++;
    total++;
    if ({init_done, ref_req, ref_busy, ref_overrun} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {init_done, ref_req, ref_busy, ref_overrun});
    else pass_cnt++;
  endtask
  task automatic test_init();
    for (int e = 0; e <= 22; e++) begin
      tick();
      total++;
      if ({cke, cmd, init_done, dqmh, dqml} !== {1'b1, init_cmd(e), e >= 22, e < 22, e < 22})
        $display("FAIL init_edge%0d: got %b want %b", e, {cke, cmd, init_done, dqmh, dqml},
          {1'b1, init_cmd(e), e >= 22, e < 22, e < 22});
      else pass_cnt++;
      if (e == 10) begin
        total++;
        if (addr[10] !== 1'b1) $display("FAIL pre_a10: got %b want 1", addr[10]);
        else pass_cnt++;
      end
      if (e == 20) begin
        total++;
        if ({addr, ba} !== {11'h020, 2'b00}) $display("FAIL mrs_addr: got %h/%h want 020/0", addr, ba);
        else pass_cnt++;
      end
    end
  endtask
  task automatic test_refresh();
    logic [3:0] exp;
    for (int e = 23; e <= 70; e++) begin
      tick();
      exp = {(e >= 42 && e <= 45) || e >= 62, e >= 46 && e <= 49, 1'b0, e == 46};
      total++;
      if ({ref_req, ref_busy, ref_overrun, cmd == 4'b0001} !== exp || (e != 46 && cmd !== 4'b0111))
        $display("FAIL refresh_edge%0d: got req/busy/ovr/ref=%b cmd=%b want %b", e,
          {ref_req, ref_busy, ref_overrun, cmd == 4'b0001}, cmd, exp);
      else pass_cnt++;
      ref_gnt = (e >= 29 && e < 35) || e == 44;
    end
    ref_gnt = 1'b0;
  endtask
  task automatic test_overrun();
    release_reset();
    test_init();
    for (int e = 23; e <= 70; e++) begin
      tick();
      total++;
      if ({ref_req, ref_overrun, ref_busy, cmd} !== {e >= 42, e >= 62, 1'b0, 4'b0111})
        $display("FAIL overrun_edge%0d: got %b want %b", e, {ref_req, ref_overrun, ref_busy, cmd},
          {e >= 42, e >= 62, 1'b0, 4'b0111});
      else pass_cnt++;
    end
  endtask
  task automatic test_no_refresh();
    for (int e = 23; e < 223; e++) begin
      ref_gnt = e[0];
      tick();
      total++;
      if ({ref_req, ref_busy, ref_overrun, init_done, cmd} !== 8'b0001_0111)
        $display("FAIL norefresh_edge%0d: got %b want 00010111", e, {ref_req, ref_busy, ref_overrun, init_done, cmd});
      else pass_cnt++;
    end
    ref_gnt = 1'b0;
  endtask
  task automatic test_mid_reset();
    release_reset();
    for (int e = 0; e <= 14; e++) tick();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({cke, cmd, dqmh, dqml, init_done, addr} !== {1'b0, 4'b1111, 2'b11, 1'b0, 11'd0})
      $display("FAIL midreset_async: got %b want 01111110_00000000000", {cke, cmd, dqmh, dqml, init_done, addr});
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_init();
  endtask
  initial begin
    test_reset();
    release_reset();
    test_init();
`ifdef SDRAM_AUTO_REFRESH_EN
    test_refresh();
    test_overrun();
`else
    test_no_refresh();
`endif
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
